// File: rtl/spi_frame_deserializer.sv
// spi_frame_deserializer: receives a 4-channel serial ADC frame on the TX SCLK
// domain, splits it into right-justified (optionally sign-extended) 24-bit
// samples and queues them in a small valid/ready FIFO.
module spi_frame_deserializer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi,
  input  logic        cs_n,
  input  logic [4:0]  cfg_bits,
  input  logic        cfg_sext,
  output logic [23:0] out_data,
  output logic [1:0]  out_ch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_RX
  } state_t;

  state_t      r_state;
  logic [4:0]  r_nm1;
  logic [4:0]  r_neff;
  logic        r_sext;
  logic [4:0]  r_bit_idx;
  logic [2:0]  r_ch_idx;
  logic        r_extra;
  logic [23:0] r_shift;
  logic        r_frame_done;
  logic        r_frame_err;
  logic        r_overflow;

  logic [25:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_start;
  logic        w_sample;
  logic [4:0]  w_nm1;
  logic [4:0]  w_neff;
  logic        w_sext;
  logic [4:0]  w_bit;
  logic [2:0]  w_ch;
  logic [23:0] w_shift;
  logic [23:0] w_shift_nxt;
  logic        w_last;
  logic        w_push;
  logic [23:0] w_lowmask;
  logic        w_sign;
  logic [23:0] w_word;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;
  logic        w_drop;

  // The first sampled edge of a frame uses the live configuration and fresh
  // counters, so the start edge and the in-frame edges share one datapath.
  always_comb begin
    w_start     = (r_state == S_IDLE);
    w_sample    = !cs_n;
    w_nm1       = w_start ? cfg_bits : r_nm1;
    w_neff      = w_start ? ((cfg_bits >= 5'd23) ? 5'd24 : cfg_bits + 5'd1) : r_neff;
    w_sext      = w_start ? cfg_sext : r_sext;
    w_bit       = w_start ? '0 : r_bit_idx;
    w_ch        = w_start ? '0 : r_ch_idx;
    w_shift     = w_start ? '0 : r_shift;
    w_shift_nxt = (w_bit < w_neff) ? {w_shift[22:0], sdi} : w_shift;
    w_last      = (w_bit == w_nm1);
    w_push      = w_sample && !w_ch[2] && w_last;
    w_lowmask   = ~(24'hFFFFFF << w_neff);
    w_sign      = w_shift_nxt[w_neff - 5'd1];
    w_word      = (w_sext && w_sign) ? (w_shift_nxt | ~w_lowmask)
                                     : (w_shift_nxt & w_lowmask);
  end

  always_comb begin
    w_pop    = out_valid && out_ready;
    w_full   = (r_count == (AW+1)'(DEPTH));
    w_accept = w_push && (!w_full || w_pop);
    w_drop   = w_push && w_full && !w_pop;
  end

  // Bits past the fourth word are tracked by a flag rather than a saturating
  // bit total; this gives the same done/err decision and stays exact for N=32,
  // where 4N lies beyond the saturation point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_nm1        <= '0;
      r_neff       <= '0;
      r_sext       <= 1'b0;
      r_bit_idx    <= '0;
      r_ch_idx     <= '0;
      r_extra      <= 1'b0;
      r_shift      <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_sample) begin
        r_state <= S_RX;
        r_nm1   <= w_nm1;
        r_neff  <= w_neff;
        r_sext  <= w_sext;
        r_extra <= (!w_start && r_extra) || w_ch[2];
        if (!w_ch[2]) begin
          if (w_last) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_ch_idx  <= w_ch + 3'd1;
          end else begin
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit + 5'd1;
            r_ch_idx  <= w_ch;
          end
        end
      end else if (r_state == S_RX) begin
        r_state <= S_IDLE;
        if (r_ch_idx[2] && !r_extra) begin
          r_frame_done <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= {w_ch[1:0], w_word};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr][23:0];
  assign out_ch     = r_mem[r_rd_ptr][25:24];
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Self-checking bench for spi_frame_deserializer with a frame-level model.
module tb_spi_frame_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdi = 1'b0;
  logic        cs_n = 1'b1;
  logic [4:0]  cfg_bits = '0;
  logic        cfg_sext = 1'b0;
  logic [23:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_done;
  logic        frame_err;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  bit          bits[$];
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  int          done_cnt = 0;
  int          err_cnt = 0;

  spi_frame_deserializer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sdi       (sdi),
    .cs_n      (cs_n),
    .cfg_bits  (cfg_bits),
    .cfg_sext  (cfg_sext),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back({out_ch, out_data});
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_val(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) bits.push_back(v[k]);
  endtask

  task automatic add_rand(input int len);
    for (int k = 0; k < len; k++) bits.push_back(bit'($urandom_range(0, 1)));
  endtask

  // Expected words: each complete N-bit slice of the first four channels,
  // first min(N,24) bits taken as an unsigned or two's-complement number.
  function automatic void model_frame(input int n, input bit sx);
    int neff;
    neff = (n > 24) ? 24 : n;
    for (int ch = 0; ch < 4; ch++) begin
      if ((ch + 1) * n <= bits.size()) begin
        longint v;
        v = 0;
        for (int k = 0; k < neff; k++) v = v * 2 + longint'(bits[ch * n + k]);
        if (sx && v >= (longint'(1) << (neff - 1))) v = v - (longint'(1) << neff);
        exp_q.push_back({ch[1:0], v[23:0]});
      end
    end
  endfunction

  task automatic send_frame(input int n, input bit sx);
    cfg_bits = 5'(n - 1);
    cfg_sext = sx;
    foreach (bits[i]) begin
      cs_n = 1'b0;
      sdi  = bits[i];
      tick();
    end
    cs_n = 1'b1;
    sdi  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", out_valid); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_data got=%h required=0", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d required=0", out_ch); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b required=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b required=0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_n24();
    int gb, d0;
    logic [23:0] vals [4] = '{24'hABCDEF, 24'h123456, 24'h800001, 24'h00FFFF};
    bits.delete(); exp_q.delete(); gb = got_q.size(); d0 = done_cnt;
    out_ready = 1'b1;
    foreach (vals[i]) add_val({8'h00, vals[i]}, 24);
    model_frame(24, 1'b0);
    send_frame(24, 1'b0);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL n24_done got=%b required=1", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL n24_err got=%b required=0", frame_err); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL n24_done_width got=%b required=0", frame_done); end
    repeat (3) tick();
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL n24_done_count got=%0d required=1", done_cnt - d0); end
    checks++; if (got_q.size() - gb != exp_q.size()) begin errors++; $display("FAIL n24_words got=%0d required=%0d", got_q.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL n24_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_sext();
    int gb;
    logic [11:0] vals [4] = '{12'h800, 12'h7FF, 12'hFFF, 12'h001};
    bits.delete(); exp_q.delete(); gb = got_q.size();
    foreach (vals[i]) add_val({20'h0, vals[i]}, 12);
    model_frame(12, 1'b1);
    send_frame(12, 1'b1);
    repeat (3) tick();
    checks++; if (got_q.size() - gb != 4) begin errors++; $display("FAIL sext_words got=%0d required=4", got_q.size() - gb); end
    if (got_q.size() > gb) begin
      checks++; if (got_q[gb] !== {2'd0, 24'hFFF800}) begin errors++; $display("FAIL sext_ch0 got=%h required=%h", got_q[gb], {2'd0, 24'hFFF800}); end
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL sext_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_n32();
    int gb;
    bits.delete(); exp_q.delete(); gb = got_q.size();
    for (int c = 0; c < 4; c++) add_val({24'($urandom), 8'h00}, 32);
    model_frame(32, 1'b0);
    send_frame(32, 1'b0);
    checks++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL n32_status got=%b%b required=10", frame_done, frame_err); end
    repeat (3) tick();
    checks++; if (got_q.size() - gb != 4) begin errors++; $display("FAIL n32_words got=%0d required=4", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL n32_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_latency();
    bits.delete(); exp_q.delete();
    out_ready = 1'b0;
    add_rand(8);
    model_frame(8, 1'b0);
    cfg_bits = 5'd7; cfg_sext = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cs_n = 1'b0; sdi = bits[i];
      tick();
      if (i == 6) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%b required=0", out_valid); end
      end
      if (i == 7) begin
        checks++; if (out_valid !== 1'b1 || {out_ch, out_data} !== exp_q[0]) begin errors++; $display("FAIL lat_word got=%b/%h required=1/%h", out_valid, {out_ch, out_data}, exp_q[0]); end
      end
    end
    cs_n = 1'b1; sdi = 1'b0;
    tick();
    checks++; if (frame_err !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL lat_err got=%b%b required=01", frame_done, frame_err); end
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1 || {out_ch, out_data} !== exp_q[0]) begin errors++; $display("FAIL lat_hold got=%b/%h required=1/%h", out_valid, {out_ch, out_data}, exp_q[0]); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_pop got=%b required=0", out_valid); end
  endtask

  task automatic test_overflow();
    int gb;
    bits.delete(); exp_q.delete(); gb = got_q.size();
    out_ready = 1'b0;
    add_rand(32);
    model_frame(8, 1'b0);
    send_frame(8, 1'b0);
    checks++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_first got=%b/%b required=0/1", overflow, out_valid); end
    bits.delete();
    add_rand(32);
    for (int i = 0; i < 32; i++) begin
      cs_n = 1'b0; sdi = bits[i]; ovf_clr = (i == 15);
      tick();
      if (i == 7) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b required=1", overflow); end
      end
      if (i == 15) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b required=1", overflow); end
      end
    end
    ovf_clr = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b required=1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b required=0", overflow); end
    out_ready = 1'b1;
    repeat (6) tick();
    checks++; if (got_q.size() - gb != 4) begin errors++; $display("FAIL ovf_words got=%0d required=4", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_full_push_pop();
    int gb;
    bits.delete(); exp_q.delete(); gb = got_q.size();
    out_ready = 1'b0;
    add_rand(32);
    model_frame(8, 1'b0);
    send_frame(8, 1'b0);
    bits.delete();
    add_rand(8);
    model_frame(2, 1'b0);
    cfg_bits = 5'd1; cfg_sext = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cs_n = 1'b0; sdi = bits[i];
      if (i == 1) out_ready = 1'b1;
      tick();
    end
    cs_n = 1'b1; sdi = 1'b0;
    repeat (8) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b required=0", overflow); end
    checks++; if (got_q.size() - gb != 8) begin errors++; $display("FAIL fullpop_words got=%0d required=8", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_short_long();
    int gb;
    exp_q.delete(); gb = got_q.size();
    out_ready = 1'b1;
    bits.delete(); add_rand(40);
    model_frame(16, 1'b0);
    send_frame(16, 1'b0);
    checks++; if (frame_err !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL short_status got=%b%b required=01", frame_done, frame_err); end
    bits.delete(); add_rand(65);
    model_frame(16, 1'b0);
    send_frame(16, 1'b0);
    checks++; if (frame_err !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL long_status got=%b%b required=01", frame_done, frame_err); end
    repeat (3) tick();
    checks++; if (got_q.size() - gb != 6) begin errors++; $display("FAIL shortlong_words got=%0d required=6", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL shortlong_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int gb, n;
    bits.delete(); exp_q.delete();
    out_ready = 1'b0;
    add_rand(30);
    cfg_bits = 5'd15; cfg_sext = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cs_n = 1'b0; sdi = bits[i];
      tick();
    end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 24'h0 || out_ch !== 2'd0) begin errors++; $display("FAIL rstmid_outputs got=%b/%h/%0d required=0/0/0", out_valid, out_data, out_ch); end
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_status got=%b%b%b required=000", frame_done, frame_err, overflow); end
    rst = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    tick();
    tick();
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_nopulse got=%b%b required=00", frame_done, frame_err); end
    out_ready = 1'b1;
    gb = got_q.size();
    n = $urandom_range(1, 24);
    bits.delete(); add_rand(4 * n);
    model_frame(n, 1'b1);
    send_frame(n, 1'b1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rstmid_clean_done got=%b required=1", frame_done); end
    repeat (3) tick();
    checks++; if (got_q.size() - gb != 4) begin errors++; $display("FAIL rstmid_words got=%0d required=4", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d got=%h required=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int gb, d0, e0, n, len, pick;
      bit sx;
      n = $urandom_range(1, 32);
      sx = bit'($urandom_range(0, 1));
      pick = $urandom_range(0, 3);
      len = (pick == 0) ? 4 * n - 1 : (pick == 1) ? 4 * n + $urandom_range(1, 5) : 4 * n;
      bits.delete(); exp_q.delete();
      gb = got_q.size(); d0 = done_cnt; e0 = err_cnt;
      add_rand(len);
      model_frame(n, sx);
      send_frame(n, sx);
      repeat (3) tick();
      checks++; if ((done_cnt - d0) != ((len == 4 * n) ? 1 : 0) || (err_cnt - e0) != ((len == 4 * n) ? 0 : 1)) begin
        errors++; $display("FAIL rand%0d_status done=%0d err=%0d required_done=%0d (n=%0d len=%0d)", f, done_cnt - d0, err_cnt - e0, (len == 4 * n) ? 1 : 0, n, len);
      end
      checks++; if (got_q.size() - gb != exp_q.size()) begin errors++; $display("FAIL rand%0d_words got=%0d required=%0d", f, got_q.size() - gb, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (gb + i < got_q.size()) begin
        checks++; if (got_q[gb + i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got=%h required=%h (n=%0d sext=%0d)", f, i, got_q[gb + i], exp_q[i], n, sx); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_n24();
    test_sext();
    test_n32();
    test_latency();
    test_overflow();
    test_full_push_pop();
    test_short_long();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
